// File: rtl/ocx_tlx_rd_sched_pkg.sv
// Shared types and helpers for the TLX data read scheduler.
// Count encoding, flit decode, queue entry layout, arbiter states.
package ocx_tlx_rd_sched_pkg;

  localparam logic [2:0] RD_CNT_1 = 3'b001;
  localparam logic [2:0] RD_CNT_2 = 3'b010;
  localparam logic [2:0] RD_CNT_4 = 3'b100;
  localparam logic [2:0] RD_CNT_8 = 3'b000;

  localparam int TAG_W_MAX = 16;

  typedef struct packed {
    logic [TAG_W_MAX-1:0] tag;
    logic [3:0]           flits;
    logic [3:0]           beats;
    logic                 bad;
  } rd_q_entry_t;

  typedef enum logic {
    GRANT_CMD_PRI  = 1'b0,
    GRANT_RESP_PRI = 1'b1
  } arb_state_t;

  // Zero flags an illegal encoding
  function automatic logic [3:0] flit_decode(input logic [2:0] cnt);
    case (cnt)
      RD_CNT_1: return 4'd1;
      RD_CNT_2: return 4'd2;
      RD_CNT_4: return 4'd4;
      RD_CNT_8: return 4'd8;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ocx_tlx_rd_sched_chan.sv
// Per-channel in-flight tag queue, beat counter and done pulse.
// Head entry accumulates beats and BDI; pops on its final beat.
module ocx_tlx_rd_sched_chan
  import ocx_tlx_rd_sched_pkg::*;
#(
  parameter int TAG_W     = 6,
  parameter int TAG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic [3:0]       push_flits,
  input  logic             data_valid,
  input  logic             data_bdi,
  output logic             full,
  output logic             beat_ok,
  output logic             unexp,
  output logic             done,
  output logic [TAG_W-1:0] done_tag,
  output logic             done_bad
);

  localparam int PW = $clog2(TAG_DEPTH);

  rd_q_entry_t   q [TAG_DEPTH];
  rd_q_entry_t   head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          empty;
  logic          last;
  logic          unused_tag_hi;

  assign head    = q[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(TAG_DEPTH));
  assign beat_ok = data_valid & ~empty;
  assign unexp   = data_valid & empty;
  assign last    = beat_ok & ((head.beats + 4'd1) == head.flits);

  assign unused_tag_hi = ^head.tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      done     <= 1'b0;
      done_tag <= '0;
      done_bad <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) q[i] <= '0;
    end else begin
      done <= last;
      if (last) begin
        done_tag <= head.tag[TAG_W-1:0];
        done_bad <= head.bad | data_bdi;
      end
      if (beat_ok) begin
        if (last) begin
          rd_ptr <= rd_ptr + PW'(1);
        end else begin
          q[rd_ptr].beats <= head.beats + 4'd1;
          q[rd_ptr].bad   <= head.bad | data_bdi;
        end
      end
      // wr_ptr never aliases a live head: push is blocked when full
      if (push) begin
        q[wr_ptr] <= '{tag:   TAG_W_MAX'(push_tag),
                       flits: push_flits,
                       beats: 4'd0,
                       bad:   1'b0};
        wr_ptr    <= wr_ptr + PW'(1);
      end
      count <= count + (PW+1)'(push) - (PW+1)'(last);
    end
  end

endmodule

// File: rtl/ocx_tlx_data_rd_sched.sv
// AFU-side round-robin read scheduler for TLX cmd/resp data FIFOs.
// Optional perf counters: define OCX_TLX_RD_SCHED_PERF_EN.
module ocx_tlx_data_rd_sched
  import ocx_tlx_rd_sched_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 16,
  parameter  int TAG_W           = 6,
  parameter  int TAG_DEPTH       = 4,
  localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             tlx_clk,
  input  logic             reset_n,
  input  logic             cmd_need_v,
  input  logic [2:0]       cmd_need_cnt,
  input  logic [TAG_W-1:0] cmd_need_tag,
  output logic             cmd_need_ready,
  input  logic             resp_need_v,
  input  logic [2:0]       resp_need_cnt,
  input  logic [TAG_W-1:0] resp_need_tag,
  output logic             resp_need_ready,
  output logic             afu_tlx_cmd_rd_req,
  output logic [2:0]       afu_tlx_cmd_rd_cnt,
  output logic             afu_tlx_resp_rd_req,
  output logic [2:0]       afu_tlx_resp_rd_cnt,
  input  logic             tlx_afu_cmd_data_valid,
  input  logic             tlx_afu_cmd_data_bdi,
  input  logic             tlx_afu_resp_data_valid,
  input  logic             tlx_afu_resp_data_bdi,
  output logic             cmd_rd_done,
  output logic [TAG_W-1:0] cmd_rd_done_tag,
  output logic             cmd_rd_done_bad,
  output logic             resp_rd_done,
  output logic [TAG_W-1:0] resp_rd_done_tag,
  output logic             resp_rd_done_bad,
`ifdef OCX_TLX_RD_SCHED_PERF_EN
  output logic [31:0]      perf_cmd_beats,
  output logic [31:0]      perf_resp_beats,
  output logic [31:0]      perf_stall_cycles,
`endif
  output logic [OW-1:0]    outstanding,
  output logic             err_unexp_data,
  output logic             err_bad_cnt
);

  arb_state_t    state;
  logic [3:0]    cmd_flits;
  logic [3:0]    resp_flits;
  logic          cmd_legal;
  logic          resp_legal;
  logic [OW-1:0] room;
  logic          cmd_elig;
  logic          resp_elig;
  logic          cmd_full;
  logic          resp_full;
  logic          grant_cmd;
  logic          grant_resp;
  logic          cmd_beat;
  logic          resp_beat;
  logic          cmd_unexp;
  logic          resp_unexp;
  logic [OW-1:0] g_flits;

  assign cmd_flits  = flit_decode(cmd_need_cnt);
  assign resp_flits = flit_decode(resp_need_cnt);
  assign cmd_legal  = |cmd_flits;
  assign resp_legal = |resp_flits;
  assign room       = OW'(MAX_OUTSTANDING) - outstanding;

  assign cmd_elig  = cmd_need_v & cmd_legal & ~cmd_full &
                     (OW'(cmd_flits) <= room);
  assign resp_elig = resp_need_v & resp_legal & ~resp_full &
                     (OW'(resp_flits) <= room);

  assign grant_cmd  = cmd_elig &
                      (~resp_elig | (state == GRANT_CMD_PRI));
  assign grant_resp = resp_elig & ~grant_cmd;

  assign cmd_need_ready  = grant_cmd;
  assign resp_need_ready = grant_resp;

  assign g_flits = grant_cmd  ? OW'(cmd_flits)  :
                   grant_resp ? OW'(resp_flits) : '0;

  ocx_tlx_rd_sched_chan #(
    .TAG_W     (TAG_W),
    .TAG_DEPTH (TAG_DEPTH)
  ) u_cmd_chan (
    .clk        (tlx_clk),
    .rst_n      (reset_n),
    .push       (grant_cmd),
    .push_tag   (cmd_need_tag),
    .push_flits (cmd_flits),
    .data_valid (tlx_afu_cmd_data_valid),
    .data_bdi   (tlx_afu_cmd_data_bdi),
    .full       (cmd_full),
    .beat_ok    (cmd_beat),
    .unexp      (cmd_unexp),
    .done       (cmd_rd_done),
    .done_tag   (cmd_rd_done_tag),
    .done_bad   (cmd_rd_done_bad)
  );

  ocx_tlx_rd_sched_chan #(
    .TAG_W     (TAG_W),
    .TAG_DEPTH (TAG_DEPTH)
  ) u_resp_chan (
    .clk        (tlx_clk),
    .rst_n      (reset_n),
    .push       (grant_resp),
    .push_tag   (resp_need_tag),
    .push_flits (resp_flits),
    .data_valid (tlx_afu_resp_data_valid),
    .data_bdi   (tlx_afu_resp_data_bdi),
    .full       (resp_full),
    .beat_ok    (resp_beat),
    .unexp      (resp_unexp),
    .done       (resp_rd_done),
    .done_tag   (resp_rd_done_tag),
    .done_bad   (resp_rd_done_bad)
  );

  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= GRANT_CMD_PRI;
      afu_tlx_cmd_rd_req  <= 1'b0;
      afu_tlx_cmd_rd_cnt  <= '0;
      afu_tlx_resp_rd_req <= 1'b0;
      afu_tlx_resp_rd_cnt <= '0;
      outstanding         <= '0;
      err_unexp_data      <= 1'b0;
      err_bad_cnt         <= 1'b0;
    end else begin
      if (grant_cmd)       state <= GRANT_RESP_PRI;
      else if (grant_resp) state <= GRANT_CMD_PRI;
      afu_tlx_cmd_rd_req  <= grant_cmd;
      afu_tlx_cmd_rd_cnt  <= grant_cmd ? cmd_need_cnt : '0;
      afu_tlx_resp_rd_req <= grant_resp;
      afu_tlx_resp_rd_cnt <= grant_resp ? resp_need_cnt : '0;
      // Beats only count against a live entry, so this cannot underflow
      outstanding <= outstanding + g_flits
                     - OW'(cmd_beat) - OW'(resp_beat);
      if (cmd_unexp | resp_unexp) err_unexp_data <= 1'b1;
      if ((cmd_need_v & ~cmd_legal) | (resp_need_v & ~resp_legal))
        err_bad_cnt <= 1'b1;
    end
  end

`ifdef OCX_TLX_RD_SCHED_PERF_EN
  logic stall;

  assign stall = ((cmd_need_v & cmd_legal) | (resp_need_v & resp_legal)) &
                 ~(grant_cmd | grant_resp);

  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cmd_beats    <= '0;
      perf_resp_beats   <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_cmd_beats    <= perf_cmd_beats + 32'(cmd_beat);
      perf_resp_beats   <= perf_resp_beats + 32'(resp_beat);
      perf_stall_cycles <= perf_stall_cycles + 32'(stall);
    end
  end
`endif

endmodule

// File: doc/ocx_tlx_data_rd_sched.md
Name: ocx_tlx_data_rd_sched

Overview:
AFU-side read scheduler for the TLX command and response data FIFOs. Two requesters, cmd-path and resp-path, each present read needs: a flit count plus a tag. The block issues afu_tlx_cmd_rd_req/afu_tlx_resp_rd_req with encoded rd_cnt, at most one request per cycle, round-robin. It bounds total outstanding flits to the shared AFU landing buffer and matches returning data beats to requests in order. It reports per-request completion with the aggregated BDI.

Parameters:
MAX_OUTSTANDING, 16, maximum flits in flight across both channels (range 8..64).
TAG_W, 6, width of requester tag.
TAG_DEPTH, 4, per-channel in-flight request queue depth (power of 2).

Ports:
tlx_clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cmd_need_v  in  1  cmd requester has a read need
cmd_need_cnt  in  3  encoded flits: 001=1, 010=2, 100=4, 000=8
cmd_need_tag  in  TAG_W  requester tag
cmd_need_ready  out  1  need accepted this cycle
resp_need_v / resp_need_cnt / resp_need_tag / resp_need_ready  same as cmd_*, resp channel
afu_tlx_cmd_rd_req  out  1  read request pulse to cmd data FIFO
afu_tlx_cmd_rd_cnt  out  3  encoded count
afu_tlx_resp_rd_req  out  1  read request pulse to resp data FIFO
afu_tlx_resp_rd_cnt  out  3  encoded count
tlx_afu_cmd_data_valid  in  1  cmd data beat returned
tlx_afu_cmd_data_bdi  in  1  bad-data for that beat
tlx_afu_resp_data_valid  in  1  resp data beat returned
tlx_afu_resp_data_bdi  in  1  bad-data for that beat
cmd_rd_done  out  1  cmd request fully returned (1-cycle pulse)
cmd_rd_done_tag  out  TAG_W  tag of completed cmd request
cmd_rd_done_bad  out  1  OR of BDI over its beats
resp_rd_done / resp_rd_done_tag / resp_rd_done_bad  out  same, resp channel
outstanding  out  clog2(MAX_OUTSTANDING+1)  flits in flight
err_unexp_data  out  1  sticky: valid beat with no request pending
err_bad_cnt  out  1  sticky: illegal need_cnt encoding seen

Behaviour:
- Reset (async assert, sync release): all outputs 0, outstanding 0, tag queues empty, round-robin pointer = cmd.
- Flits decode: 001→1, 010→2, 100→4, 000→8. Any other encoding: need not accepted; err_bad_cnt set while need_v is high.
- Channel eligible: need_v, legal cnt, flits ≤ MAX_OUTSTANDING − outstanding, and tag queue not full.
- Arbiter FSM states:
  - GRANT_CMD_PRI: cmd wins ties.
  - GRANT_RESP_PRI: resp wins ties.
  - Transition: a grant moves the FSM to the other channel's priority state; no grant leaves state unchanged.
- need_ready is combinational, asserted only for the granted channel; at most one grant per cycle.
- Issue latency:
  - Grant in cycle N → rd_req=1 with the registered cnt in cycle N+1 for exactly one cycle. Back-to-back grants are allowed.
  - Tag, flits and a zeroed bdi accumulator are pushed into the channel queue in cycle N.
- outstanding_next = outstanding + granted_flits − cmd_valid_counted − resp_valid_counted. Both valids plus a grant in the same cycle must net correctly; never underflow.
- Beat matching, per channel: the head entry counts beats and ORs BDI into its accumulator. When beats == flits, pop the entry and pulse done with the tag and bad = accumulated OR including the final beat. Done is registered, one cycle after the last valid.
- A grant push and a final-beat pop on the same queue in the same cycle are both honoured; a full queue with a simultaneous pop still blocks the grant.
- Valid with an empty queue: beat ignored, outstanding unchanged, err_unexp_data set. Sticky errors clear only on reset.
- Reset mid-operation discards all queued state; no done pulses follow.

Optional Feature:
OCX_TLX_RD_SCHED_PERF_EN:
- Defined: adds outputs perf_cmd_beats[31:0], perf_resp_beats[31:0] and perf_stall_cycles[31:0]. Stall counts cycles with any need_v high and no grant, excluding illegal encodings. Counters wrap and reset to 0.
- Undefined: ports and logic absent.

Decomposition:
- Package ocx_tlx_rd_sched_pkg: rd_cnt encoding constants, flit-decode function, queue-entry typedef (tag, flits[3:0], beats[3:0], bad).
- One sub-module, ocx_tlx_rd_sched_chan, instantiated twice: tag queue, beat counter, done generation.

Test Plan:
- Single cmd need cnt=010 tag=5 → afu_tlx_cmd_rd_req one cycle later with cnt=010, outstanding=2. Two valid beats, second with bdi=1 → cmd_rd_done tag=5 bad=1; outstanding=0.
- cmd and resp both need cnt=001 every cycle → grants alternate cmd, resp, cmd…; never two rd_req in one cycle.
- MAX_OUTSTANDING=16, cmd issues 000 twice (16 flits) → resp cnt=001 held off (ready=0) until the first beat returns, then granted.
- Same-cycle cmd valid, resp valid and new grant of 4 from outstanding=6 → outstanding=8.
- resp valid with empty queue → err_unexp_data=1, outstanding stays 0. need_cnt=011 → err_bad_cnt=1, no rd_req.
- reset_n low with 3 requests queued → all outputs 0 immediately; after release, no done pulses and outstanding=0.
